// File: rtl/accum_pkg.sv
// Shared types and constants for the accumulation-buffer sequencer.
// Clamp bounds are used only when ACCUM_SEQ_CLAMP_EN is defined.
package accum_pkg;

  localparam int ACC_DATA_W = 32;
  localparam int CLAMP_MIN  = -128;
  localparam int CLAMP_MAX  = 127;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    READ  = 2'd2
  } acc_state_e;

endpackage

// File: rtl/accum_res_fifo.sv
// Synchronous result FIFO, registered storage, power-of-two depth.
// Ports: push_i/push_data_i in, pop_i in, head_o/count_o/full_o/empty_o out.
module accum_res_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];

  always_comb begin
    do_push = push_i && (!full_o || pop_i);
    do_pop  = pop_i && !empty_o;
    wptr_d  = wptr_q + AW'(do_push);
    rptr_d  = rptr_q + AW'(do_pop);
    count_d = count_q;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= push_data_i;
  end

endmodule

// File: rtl/accum_seq_ctrl.sv
// Sequencer for the per-lane accumulation buffer: writes partial sums,
// issues one read/clear per group and queues results in a small FIFO.
// Ports: cfg_* config, psum_* in stream, acc_* buffer side,
// res_* out stream, busy_o/fifo_count_o status.
// Option ACCUM_SEQ_CLAMP_EN: clamp pushed result to signed [-128,127].
module accum_seq_ctrl
  import accum_pkg::*;
#(
  parameter int DATA_W     = ACC_DATA_W,
  parameter int LEN_W      = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [LEN_W-1:0]  cfg_acc_len_i,
  input  logic [DATA_W-1:0] cfg_zero_point_i,
  input  logic              psum_valid_i,
  output logic              psum_ready_o,
  input  logic [DATA_W-1:0] psum_data_i,
  output logic              acc_write_en_o,
  output logic [DATA_W-1:0] acc_data_o,
  output logic              acc_read_en_o,
  output logic [DATA_W-1:0] acc_zero_point_o,
  input  logic [DATA_W-1:0] acc_data_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [DATA_W-1:0] res_data_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  fifo_count_o
);

  acc_state_e        state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [DATA_W-1:0] zp_q, zp_d;
  logic [LEN_W-1:0]  len_eff;
  logic [DATA_W-1:0] push_data;
  logic              hs;
  logic              fifo_full;
  logic              fifo_empty;

  // A free slot is required up front so the group's result never overflows.
  assign psum_ready_o = rst_ni && (state_q != READ) && !fifo_full;
  assign hs           = psum_valid_i && psum_ready_o;

  assign acc_write_en_o   = hs;
  assign acc_data_o       = psum_data_i;
  assign acc_read_en_o    = (state_q == READ);
  assign acc_zero_point_o = zp_q;

  assign res_valid_o = !fifo_empty;
  assign busy_o      = (state_q != IDLE) || !fifo_empty;

  assign len_eff = (cfg_acc_len_i == '0) ? LEN_W'(1) : cfg_acc_len_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    zp_d    = zp_q;
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          len_d = len_eff;
          zp_d  = cfg_zero_point_i;
          cnt_d = LEN_W'(1);
          state_d = (len_eff == LEN_W'(1)) ? READ : ACCUM;
        end
      end
      ACCUM: begin
        if (hs) begin
          if (cnt_q == len_q - LEN_W'(1)) state_d = READ;
          else cnt_d = cnt_q + LEN_W'(1);
        end
      end
      READ: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= LEN_W'(1);
      zp_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      zp_q    <= zp_d;
    end
  end

`ifdef ACCUM_SEQ_CLAMP_EN
  localparam logic signed [DATA_W-1:0] C_MAX = DATA_W'(CLAMP_MAX);
  localparam logic signed [DATA_W-1:0] C_MIN = DATA_W'(CLAMP_MIN);

  always_comb begin
    push_data = acc_data_i;
    if ($signed(acc_data_i) > C_MAX) push_data = C_MAX;
    else if ($signed(acc_data_i) < C_MIN) push_data = C_MIN;
  end
`else
  assign push_data = acc_data_i;
`endif

  accum_res_fifo #(
    .DW    (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (acc_read_en_o),
    .push_data_i (push_data),
    .pop_i       (res_ready_i),
    .head_o      (res_data_o),
    .count_o     (fifo_count_o),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

endmodule

// File: tb/tb_accum_seq_ctrl.sv
// Bench for accum_seq_ctrl: attached buffer model, group-level
// reference queue, directed cases then randomized groups.
module tb_accum_seq_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [7:0]  cfg_acc_len_i = 8'd1;
  logic [31:0] cfg_zero_point_i = '0;
  logic        psum_valid_i = 1'b0;
  logic        psum_ready_o;
  logic [31:0] psum_data_i = '0;
  logic        acc_write_en_o;
  logic [31:0] acc_data_o;
  logic        acc_read_en_o;
  logic [31:0] acc_zero_point_o;
  logic [31:0] acc_data_i;
  logic        res_valid_o;
  logic        res_ready_i = 1'b0;
  logic [31:0] res_data_o;
  logic        busy_o;
  logic [2:0]  fifo_count_o;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0, rd_cnt = 0;
  int exp_wr = 0, exp_rd = 0;
  int rmode = 0;
  logic [31:0] exp_q[$];
  logic [31:0] beats[8];
  logic [31:0] acc_m;

  accum_seq_ctrl dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .cfg_acc_len_i    (cfg_acc_len_i),
    .cfg_zero_point_i (cfg_zero_point_i),
    .psum_valid_i     (psum_valid_i),
    .psum_ready_o     (psum_ready_o),
    .psum_data_i      (psum_data_i),
    .acc_write_en_o   (acc_write_en_o),
    .acc_data_o       (acc_data_o),
    .acc_read_en_o    (acc_read_en_o),
    .acc_zero_point_o (acc_zero_point_o),
    .acc_data_i       (acc_data_i),
    .res_valid_o      (res_valid_o),
    .res_ready_i      (res_ready_i),
    .res_data_o       (res_data_o),
    .busy_o           (busy_o),
    .fifo_count_o     (fifo_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Accumulation buffer: sums writes, read returns sum+zp and clears.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) acc_m <= '0;
    else if (acc_read_en_o) acc_m <= '0;
    else if (acc_write_en_o) acc_m <= acc_m + acc_data_o;
  end
  assign acc_data_i = acc_read_en_o ? acc_m + acc_zero_point_o
                                    : 32'hdeadbeef;

  function automatic logic [31:0] model_res(input logic [31:0] s);
`ifdef ACCUM_SEQ_CLAMP_EN
    if ($signed(s) > 127) return 32'd127;
    if ($signed(s) < -128) return 32'hffffff80;
`endif
    return s;
  endfunction

  always @(posedge clk_i) begin
    #1;
    case (rmode)
      0: res_ready_i = 1'b1;
      1: res_ready_i = 1'b0;
      default: res_ready_i = 1'($urandom % 2);
    endcase
  end

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (acc_write_en_o) wr_cnt++;
      if (acc_read_en_o) rd_cnt++;
      if (res_valid_o && res_ready_i) begin
        if (exp_q.size() == 0) check("extra_res", res_data_o, 32'hx);
        else check("res", res_data_o, exp_q.pop_front());
      end
    end
  end

  task automatic send_beat(input logic [31:0] d);
    bit done = 0;
    psum_valid_i = 1'b1;
    psum_data_i  = d;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk_i);
      if (psum_ready_o) done = 1;
      @(posedge clk_i);
      #1;
    end
    psum_valid_i = 1'b0;
    if (!done) check("hs_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_group(input int len, input logic [31:0] zp,
                           input bit chg);
    logic [31:0] s;
    int n;
    n = (len == 0) ? 1 : len;
    s = zp;
    for (int i = 0; i < n; i++) s = s + beats[i];
    exp_q.push_back(model_res(s));
    exp_wr += n;
    exp_rd += 1;
    cfg_acc_len_i    = 8'(len);
    cfg_zero_point_i = zp;
    for (int i = 0; i < n; i++) begin
      send_beat(beats[i]);
      if (chg && i == 1) begin
        cfg_acc_len_i    = 8'd2;
        cfg_zero_point_i = 32'd99;
      end
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_i);
      if (exp_q.size() == 0 && fifo_count_o == 0 && !busy_o) break;
    end
    check("drain", 32'(exp_q.size()) + 32'(fifo_count_o), 32'd0);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    psum_valid_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check("rst_ready", 32'(psum_ready_o), 32'd0);
    check("rst_wr", 32'(acc_write_en_o), 32'd0);
    check("rst_rd", 32'(acc_read_en_o), 32'd0);
    check("rst_valid", 32'(res_valid_o), 32'd0);
    check("rst_count", 32'(fifo_count_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_zp", acc_zero_point_o, 32'd0);
    psum_valid_i = 1'b0;
    #1 rst_ni = 1'b1;
    @(negedge clk_i);
    check("idle_ready", 32'(psum_ready_o), 32'd1);
    @(posedge clk_i);
    #1;

    // len=4 zp=10, beats 1..4, check read pulse and result latency
    rmode = 1;
    @(posedge clk_i);
    #2;
    beats[0] = 1; beats[1] = 2; beats[2] = 3; beats[3] = 4;
    run_group(4, 32'd10, 0);
    @(negedge clk_i);
    check("rd_pulse", 32'(acc_read_en_o), 32'd1);
    check("rd_zp", acc_zero_point_o, 32'd10);
    check("rd_ready", 32'(psum_ready_o), 32'd0);
    @(negedge clk_i);
    check("lat_valid", 32'(res_valid_o), 32'd1);
    check("lat_data", res_data_o, model_res(32'd20));
    check("lat_count", 32'(fifo_count_o), 32'd1);
    check("wr4", 32'(wr_cnt), 32'd4);
    check("rd1", 32'(rd_cnt), 32'd1);
    rmode = 0;
    wait_drain();

    // len=0 treated as 1
    beats[0] = 7;
    run_group(0, 32'd0, 0);
    @(negedge clk_i);
    check("len0_rd", 32'(acc_read_en_o), 32'd1);
    wait_drain();

    // FIFO fill with downstream stalled
    rmode = 1;
    @(posedge clk_i);
    #2;
    for (int k = 0; k < 4; k++) begin
      beats[0] = 32'(11 + k);
      run_group(1, 32'd0, 0);
    end
    psum_valid_i = 1'b1;
    psum_data_i  = 32'd15;
    repeat (5) @(negedge clk_i);
    check("full_ready", 32'(psum_ready_o), 32'd0);
    check("full_count", 32'(fifo_count_o), 32'd4);
    check("full_busy", 32'(busy_o), 32'd1);
    check("full_wr", 32'(wr_cnt), 32'(exp_wr));
    @(posedge clk_i);
    #1;
    psum_valid_i = 1'b0;
    rmode = 0;
    beats[0] = 15;
    run_group(1, 32'd0, 0);
    beats[0] = 16;
    run_group(1, 32'd0, 0);
    wait_drain();

    // cfg change mid-group ignored
    beats[0] = 3; beats[1] = 4; beats[2] = 5; beats[3] = 6;
    run_group(4, 32'd1000, 1);
    wait_drain();

    // reset in the middle of a group
    cfg_acc_len_i    = 8'd4;
    cfg_zero_point_i = 32'd50;
    send_beat(32'd9);
    send_beat(32'd9);
    exp_wr += 2;
    rst_ni = 1'b0;
    @(negedge clk_i);
    check("mid_rst_rd", 32'(acc_read_en_o), 32'd0);
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    check("mid_rst_count", 32'(fifo_count_o), 32'd0);
    check("mid_rst_zp", acc_zero_point_o, 32'd0);
    check("mid_rst_ready", 32'(psum_ready_o), 32'd0);
    #1 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    beats[0] = 5; beats[1] = 5;
    run_group(2, 32'd3, 0);
    wait_drain();

    // values that exercise the optional clamp
    beats[0] = 100; beats[1] = 100;
    run_group(2, 32'd0, 0);
    beats[0] = -32'sd200; beats[1] = 0;
    run_group(2, 32'd0, 0);
    wait_drain();

    // randomized groups with random downstream backpressure
    rmode = 2;
    for (int g = 0; g < 25; g++) begin
      int len;
      len = $urandom_range(0, 6);
      for (int i = 0; i < 8; i++)
        beats[i] = ($urandom % 4 == 0) ? $urandom
                                        : 32'($urandom_range(0, 300)) - 150;
      run_group(len, 32'($urandom_range(0, 40)) - 20, 0);
    end
    rmode = 0;
    wait_drain();

    check("total_wr", 32'(wr_cnt), 32'(exp_wr));
    check("total_rd", 32'(rd_cnt), 32'(exp_rd));
    check("end_busy", 32'(busy_o), 32'd0);
    check("end_valid", 32'(res_valid_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/accum_seq_ctrl.md
Name: accum_seq_ctrl

Overview:
- Sequencer driving the write/read side of the per-lane output accumulation buffer.
- Accepts a valid/ready stream of 32-bit partial sums from the PIM macro readout.
- Issues one accumulate-write per partial sum. After ACC_LEN beats, issues a single read/clear pulse carrying the zero point, and captures the buffer's combinational result into a small output FIFO.
- Presents the results downstream on a valid/ready interface for the output formatter / bus bridge.

Parameters:
- DATA_W, 32, partial-sum and result width
- LEN_W, 8, width of the accumulation-length config
- FIFO_DEPTH, 4, result FIFO entries (power of two, >=2)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- cfg_acc_len_i  in  LEN_W  partial sums per result; 0 treated as 1
- cfg_zero_point_i  in  DATA_W  zero point added on read
- psum_valid_i  in  1  partial sum valid
- psum_ready_o  out  1  partial sum accepted when valid&ready
- psum_data_i  in  DATA_W  partial sum
- acc_write_en_o  out  1  to buffer write_en
- acc_data_o  out  DATA_W  to buffer data input
- acc_read_en_o  out  1  to buffer read_en
- acc_zero_point_o  out  DATA_W  to buffer zero_point
- acc_data_i  in  DATA_W  from buffer result output (valid only while read_en high)
- res_valid_o  out  1  result available
- res_ready_i  in  1  downstream accepts
- res_data_o  out  DATA_W  result (FIFO head)
- busy_o  out  1  group in progress or FIFO non-empty
- fifo_count_o  out  $clog2(FIFO_DEPTH)+1  occupied FIFO entries

Behaviour:
- Reset values: state IDLE, beat counter 0, latched len 1, latched zero point 0, FIFO empty.
  - All outputs low/zero: psum_ready_o=0 during reset, res_valid_o=0, fifo_count_o=0.
- FSM states: IDLE, ACCUM, READ.
- psum_ready_o = (state==IDLE or ACCUM) and fifo_count_o < FIFO_DEPTH. A FIFO slot must be free before any beat of a group is accepted.
- Beat handshake:
  - acc_write_en_o = psum_valid_i & psum_ready_o (combinational).
  - acc_data_o = psum_data_i.
- IDLE, on a handshake:
  - Latch len = max(cfg_acc_len_i,1) and cfg_zero_point_i.
  - If len==1 go to READ; else counter=1, go to ACCUM.
- ACCUM, on a handshake:
  - If counter==len-1 go to READ; else counter++.
  - cfg changes mid-group are ignored.
- READ, lasting exactly one cycle:
  - acc_read_en_o=1, acc_zero_point_o=latched zero point.
  - psum_ready_o=0.
  - Push acc_data_i into the FIFO at the clock edge, then go to IDLE.
- acc_zero_point_o outside READ = latched value; the buffer ignores it.
- Latency: last beat accepted at edge t → READ during cycle t..t+1 → res_valid_o high after edge t+1.
- The FIFO cannot overflow: the slot is checked at group start and the FIFO only pops otherwise.
- FIFO:
  - Registered storage; res_valid_o = count!=0; res_data_o = head.
  - Simultaneous push and pop: count unchanged, ordering preserved.
  - Pointers wrap modulo FIFO_DEPTH.
- Back-to-back groups: the first beat of the next group may be accepted the cycle after READ (one bubble per group).
- Arithmetic: no arithmetic in this block beyond counter compare; the sum is formed in the buffer; no width extension.
- Reset mid-group: sequencer returns to IDLE. The buffer shares rst_ni, so partial accumulation is discarded consistently and no stale read pulse is issued.
- busy_o = state!=IDLE or fifo_count_o!=0.

Optional Feature:
- Macro ACCUM_SEQ_CLAMP_EN.
- Defined: the captured value is clamped as signed to [-128,127] before the FIFO push; upper bits are sign-extended. Adds one compare stage in the push path only; latency unchanged.
- Undefined: the full DATA_W result is pushed unmodified.

Decomposition:
- Shared package accum_pkg:
  - Typedef acc_state_e {IDLE, ACCUM, READ}.
  - Constants ACC_DATA_W=32, CLAMP_MIN=-128, CLAMP_MAX=127.
- One sub-module: accum_res_fifo, a parameterised synchronous FIFO with push/pop/count.
- The FSM and counter stay in accum_seq_ctrl.

Test Plan:
- len=4, zp=10, beats 1,2,3,4 back-to-back, buffer model attached → four write pulses, one read pulse, res_data_o=20 one cycle after the read.
- len=0 → treated as 1. Beat 7 with zp=0 → read pulse on the next cycle, result 7.
- res_ready_i=0, len=1, FIFO_DEPTH=4, six beats offered → four results queued, psum_ready_o low. Releasing ready drains in order and resumes acceptance.
- Change cfg_acc_len_i 4→2 and zp after the second beat → group still completes after 4 beats with the original zp.
- rst_ni asserted after 2 of 4 beats → all outputs zero, FIFO empty, no read pulse. Next group len=2 of 5,5 gives result 10+zp.
- With ACCUM_SEQ_CLAMP_EN, len=2, beats 100,100 → result 127; beats -200,0 → -128. Without the macro → 200 and -200.
